// File: rtl/uart_seq_pkg.sv
// Shared encodings and default sizing for the UART filter sequencer.
package uart_seq_pkg;

    typedef enum logic [2:0] {
        S_RX       = 3'd0,
        S_RX_GAP   = 3'd1,
        S_FLT_REQ  = 3'd2,
        S_FLT_WAIT = 3'd3,
        S_TX       = 3'd4,
        S_TX_GAP   = 3'd5
    } seq_state_t;

    localparam int DEF_DBITS        = 8;
    localparam int DEF_SAMPLE_BYTES = 2;
    localparam int DEF_TIMEOUT_CYC  = 1000000;

    // Index width that stays legal when only one value is needed.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Idle counter for partial samples: counts enabled cycles and flags the last one.
module seq_timeout_counter
    import uart_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
    input  logic clk_100MHz,
    input  logic reset_btn_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int            CW   = idx_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    assign expire = enable && !clear && (count == LAST);

    // Expiry restarts the count so the next partial sample gets a full window.
    always_ff @(posedge clk_100MHz or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_filter_sequencer.sv
// Pops RX bytes into little-endian samples, runs them through the filter and pushes results to TX.
// Define SEQ_STATS_EN to add the sample_count/drop_count statistics outputs.
module uart_filter_sequencer
    import uart_seq_pkg::*;
#(
    parameter int DBITS        = DEF_DBITS,
    parameter int SAMPLE_BYTES = DEF_SAMPLE_BYTES,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
)(
    input  logic                          clk_100MHz,
    input  logic                          reset_btn_n,
    input  logic                          rx_empty,
    input  logic [DBITS-1:0]              rx_data,
    output logic                          rd_uart,
    input  logic                          tx_full,
    output logic                          wr_uart,
    output logic [DBITS-1:0]              wr_data,
    output logic                          flt_in_valid,
    input  logic                          flt_in_ready,
    output logic [DBITS*SAMPLE_BYTES-1:0] flt_in_data,
    input  logic                          flt_out_valid,
    output logic                          flt_out_ready,
    input  logic [DBITS*SAMPLE_BYTES-1:0] flt_out_data,
    output logic                          busy,
    output logic                          timeout_tick
`ifdef SEQ_STATS_EN
    ,
    output logic [15:0]                   sample_count,
    output logic [7:0]                    drop_count
`endif
);

    localparam int               SW        = DBITS * SAMPLE_BYTES;
    localparam int               IDX_W     = idx_width(SAMPLE_BYTES);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(SAMPLE_BYTES - 1);

    seq_state_t        state, state_n;
    logic [IDX_W-1:0]  byte_idx, byte_idx_n;
    logic [IDX_W-1:0]  tx_idx, tx_idx_n;
    logic [SW-1:0]     sample_n;
    logic [SW-1:0]     tx_shift, tx_shift_n;
    logic [DBITS-1:0]  wr_data_n;
    logic              rd_n, wr_n, fin_valid_n, fout_ready_n, tick_n;
    logic              tmo_en, tmo_clr, tmo_expire;

    assign tmo_en  = (state == S_RX) && (byte_idx != '0) && rx_empty;
    assign tmo_clr = (state == S_RX) && !rx_empty;
    assign busy    = !((state == S_RX) && (byte_idx == '0));

    seq_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_100MHz  (clk_100MHz),
        .reset_btn_n (reset_btn_n),
        .enable      (tmo_en),
        .clear       (tmo_clr),
        .expire      (tmo_expire)
    );

    always_comb begin
        state_n      = state;
        byte_idx_n   = byte_idx;
        tx_idx_n     = tx_idx;
        sample_n     = flt_in_data;
        tx_shift_n   = tx_shift;
        wr_data_n    = wr_data;
        rd_n         = 1'b0;
        wr_n         = 1'b0;
        tick_n       = 1'b0;
        fin_valid_n  = flt_in_valid;
        fout_ready_n = flt_out_ready;
        case (state)
            S_RX: begin
                if (!rx_empty) begin
                    rd_n = 1'b1;
                    sample_n[byte_idx*DBITS +: DBITS] = rx_data;
                    state_n = S_RX_GAP;
                end else if (tmo_expire) begin
                    byte_idx_n = '0;
                    tick_n     = 1'b1;
                end
            end
            // Gap cycle lets the RX FIFO flags reflect the pop before the next look.
            S_RX_GAP: begin
                if (byte_idx == LAST_LANE) begin
                    byte_idx_n  = '0;
                    fin_valid_n = 1'b1;
                    state_n     = S_FLT_REQ;
                end else begin
                    byte_idx_n = byte_idx + 1'b1;
                    state_n    = S_RX;
                end
            end
            S_FLT_REQ: begin
                if (flt_in_ready) begin
                    fin_valid_n  = 1'b0;
                    fout_ready_n = 1'b1;
                    state_n      = S_FLT_WAIT;
                end
            end
            S_FLT_WAIT: begin
                if (flt_out_valid) begin
                    tx_shift_n   = flt_out_data;
                    fout_ready_n = 1'b0;
                    state_n      = S_TX;
                end
            end
            S_TX: begin
                if (!tx_full) begin
                    wr_n      = 1'b1;
                    wr_data_n = tx_shift[tx_idx*DBITS +: DBITS];
                    state_n   = S_TX_GAP;
                end
            end
            S_TX_GAP: begin
                if (tx_idx == LAST_LANE) begin
                    tx_idx_n = '0;
                    state_n  = S_RX;
                end else begin
                    tx_idx_n = tx_idx + 1'b1;
                    state_n  = S_TX;
                end
            end
            default: state_n = S_RX;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            state         <= S_RX;
            byte_idx      <= '0;
            tx_idx        <= '0;
            flt_in_data   <= '0;
            tx_shift      <= '0;
            wr_data       <= '0;
            rd_uart       <= 1'b0;
            wr_uart       <= 1'b0;
            flt_in_valid  <= 1'b0;
            flt_out_ready <= 1'b0;
            timeout_tick  <= 1'b0;
        end else begin
            state         <= state_n;
            byte_idx      <= byte_idx_n;
            tx_idx        <= tx_idx_n;
            flt_in_data   <= sample_n;
            tx_shift      <= tx_shift_n;
            wr_data       <= wr_data_n;
            rd_uart       <= rd_n;
            wr_uart       <= wr_n;
            flt_in_valid  <= fin_valid_n;
            flt_out_ready <= fout_ready_n;
            timeout_tick  <= tick_n;
        end
    end

`ifdef SEQ_STATS_EN
    // A sample counts as complete when its last lane leaves the TX gap state.
    always_ff @(posedge clk_100MHz or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            sample_count <= '0;
            drop_count   <= '0;
        end else begin
            if ((state == S_TX_GAP) && (tx_idx == LAST_LANE))
                sample_count <= sample_count + 16'd1;
            if (tick_n && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_filter_sequencer.sv
// Randomized self-checking bench: RX FIFO, filter (+1) and TX sink models with a sample-level scoreboard.
module tb_uart_filter_sequencer;

    localparam int DBITS = 8;
    localparam int SB    = 2;
    localparam int TO    = 16;
    localparam int SW    = DBITS * SB;

    logic              clk_100MHz = 1'b0;
    logic              reset_btn_n;
    logic              rx_empty;
    logic [DBITS-1:0]  rx_data;
    logic              rd_uart;
    logic              tx_full;
    logic              wr_uart;
    logic [DBITS-1:0]  wr_data;
    logic              flt_in_valid;
    logic              flt_in_ready;
    logic [SW-1:0]     flt_in_data;
    logic              flt_out_valid;
    logic              flt_out_ready;
    logic [SW-1:0]     flt_out_data;
    logic              busy;
    logic              timeout_tick;
`ifdef SEQ_STATS_EN
    logic [15:0]       sample_count;
    logic [7:0]        drop_count;
`endif

    always #5 clk_100MHz = ~clk_100MHz;

    uart_filter_sequencer #(
        .DBITS        (DBITS),
        .SAMPLE_BYTES (SB),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk_100MHz    (clk_100MHz),
        .reset_btn_n   (reset_btn_n),
        .rx_empty      (rx_empty),
        .rx_data       (rx_data),
        .rd_uart       (rd_uart),
        .tx_full       (tx_full),
        .wr_uart       (wr_uart),
        .wr_data       (wr_data),
        .flt_in_valid  (flt_in_valid),
        .flt_in_ready  (flt_in_ready),
        .flt_in_data   (flt_in_data),
        .flt_out_valid (flt_out_valid),
        .flt_out_ready (flt_out_ready),
        .flt_out_data  (flt_out_data),
        .busy          (busy),
        .timeout_tick  (timeout_tick)
`ifdef SEQ_STATS_EN
        ,
        .sample_count  (sample_count),
        .drop_count    (drop_count)
`endif
    );

    logic [DBITS-1:0] rx_q[$];
    logic [SW-1:0]    exp_samp[$];
    logic [DBITS-1:0] exp_tx[$];
    logic [SW-1:0]    flt_res[$];
    int               flt_due[$];
    int ready_mode, tx_mode, lat;
    int n_tests, n_fail;
    int cyc;
    int wr_count, tx_bytes, ticks_seen;
    bit rst_on_fout, rst_fired, out_hs_pending;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected behaviour derived at sample level: LE assembly, filter result = sample + 1, LE emission.
    task automatic push_sample(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s + 1'b1;
        for (int i = 0; i < SB; i++) begin
            rx_q.push_back(s[i*DBITS +: DBITS]);
            exp_tx.push_back(r[i*DBITS +: DBITS]);
        end
        exp_samp.push_back(s);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_samp.size() != 0 || rx_q.size() != 0 || busy) && n < bound) begin
            @(negedge clk_100MHz); #1;
            n++;
        end
        chk(tag, (n < bound), 1);
    endtask

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    // Environment models, all driven at the falling edge.
    always @(negedge clk_100MHz) begin : env
        logic [SW-1:0] s;
        if (!reset_btn_n) begin
            flt_res.delete();
            flt_due.delete();
            flt_out_valid  = 1'b0;
            flt_in_ready   = 1'b0;
            out_hs_pending = 1'b0;
            tx_full        = 1'b0;
        end else begin
            if (rd_uart) begin
                if (rx_q.size() > 0) rx_q.delete(0);
                else chk("rd_on_empty_fifo", 1, 0);
            end
            if (wr_uart) begin
                wr_count++;
                tx_bytes++;
                if (exp_tx.size() > 0) chk("tx_byte", wr_data, exp_tx.pop_front());
                else chk("tx_unexpected_push", 1, 0);
            end
            if (rd_uart && wr_uart) chk("rd_wr_overlap", 1, 0);
            if (timeout_tick) ticks_seen++;
            if (out_hs_pending) begin
                flt_out_valid  = 1'b0;
                out_hs_pending = 1'b0;
            end
            if (!flt_out_valid && flt_res.size() > 0 && cyc >= flt_due[0]) begin
                flt_out_valid = 1'b1;
                flt_out_data  = flt_res.pop_front();
                flt_due.delete(0);
            end
            if (flt_out_valid && flt_out_ready) begin
                if (rst_on_fout) begin
                    reset_btn_n = 1'b0;
                    rst_on_fout = 1'b0;
                    rst_fired   = 1'b1;
                    tx_bytes    = 0;
                    ticks_seen  = 0;
                    flt_res.delete();
                    flt_due.delete();
                end else begin
                    out_hs_pending = 1'b1;
                end
            end
            flt_in_ready = (ready_mode == 0) ? 1'b0 : (ready_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            if (flt_in_valid && flt_in_ready) begin
                s = flt_in_data;
                if (exp_samp.size() > 0) chk("flt_in_data", s, exp_samp.pop_front());
                else chk("flt_unexpected_sample", 1, 0);
                flt_res.push_back(s + 1'b1);
                flt_due.push_back(cyc + lat);
            end
            tx_full = (tx_mode == 1) ? 1'b1 : (tx_mode == 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
        end
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? '0 : rx_q[0];
    end

    initial begin
        int n, t0, bad;
        logic [SW-1:0] d;
        n_tests = 0; n_fail = 0; cyc = 0;
        wr_count = 0; tx_bytes = 0; ticks_seen = 0;
        ready_mode = 2; tx_mode = 2; lat = 3;
        rst_on_fout = 0; rst_fired = 0; out_hs_pending = 0;
        rx_empty = 1'b1; rx_data = '0; tx_full = 1'b0;
        flt_in_ready = 1'b0; flt_out_valid = 1'b0; flt_out_data = '0;
        reset_btn_n = 1'b1;
        #1 reset_btn_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_100MHz);
        #1;
        chk("rst_rd_uart", rd_uart, 0);
        chk("rst_wr_uart", wr_uart, 0);
        chk("rst_flt_in_valid", flt_in_valid, 0);
        chk("rst_flt_out_ready", flt_out_ready, 0);
        chk("rst_flt_in_data", flt_in_data, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_tick", timeout_tick, 0);
        reset_btn_n = 1'b1;
        @(negedge clk_100MHz); #1;
        chk("release_no_pulse", {rd_uart, wr_uart, timeout_tick}, 0);

        // Basic sample 0x1234 through the +1 filter
        wr_count = 0;
        push_sample(16'h1234);
        wait_idle("drain_basic", 200);
        chk("basic_wr_pulses", wr_count, 2);

        // Filter stalls input handshake for 20 cycles
        ready_mode = 0;
        push_sample(16'hBEEF);
        push_sample(16'h0A0B);
        n = 0;
        while (!flt_in_valid && n < 100) begin @(negedge clk_100MHz); #1; n++; end
        chk("hold_valid_seen", flt_in_valid, 1);
        d = flt_in_data;
        chk("hold_data", d, 16'hBEEF);
        bad = 0;
        repeat (20) begin
            @(negedge clk_100MHz); #1;
            if (!flt_in_valid || flt_in_data !== d || rd_uart) bad++;
        end
        chk("hold_violations", bad, 0);
        ready_mode = 2;
        wait_idle("drain_hold", 400);

        // TX FIFO full for 50 cycles after the result is accepted
        tx_mode = 1;
        wr_count = 0;
        push_sample(16'h5678);
        n = 0;
        while (!(flt_out_valid && flt_out_ready) && n < 200) begin @(negedge clk_100MHz); #1; n++; end
        chk("txfull_result_seen", (n < 200), 1);
        repeat (50) begin @(negedge clk_100MHz); #1; end
        chk("txfull_no_wr", wr_count, 0);
        tx_mode = 2;
        n = 0;
        while (!wr_uart && n < 10) begin @(negedge clk_100MHz); #1; n++; end
        chk("txfull_release_latency", (n >= 1 && n <= 2), 1);
        wait_idle("drain_txfull", 200);
        chk("txfull_wr_pulses", wr_count, 2);

        // Reset while the filter result is being offered
        lat = 5;
        rst_fired = 0;
        rst_on_fout = 1;
        push_sample(16'h2222);
        n = 0;
        while (!rst_fired && n < 200) begin @(negedge clk_100MHz); n++; end
        #1;
        chk("midrst_fired", rst_fired, 1);
        chk("midrst_rd_uart", rd_uart, 0);
        chk("midrst_wr_uart", wr_uart, 0);
        chk("midrst_flt_in_valid", flt_in_valid, 0);
        chk("midrst_flt_out_ready", flt_out_ready, 0);
        chk("midrst_flt_in_data", flt_in_data, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_busy", busy, 0);
        exp_tx.delete();
        exp_samp.delete();
        rx_q.delete();
        repeat (3) @(negedge clk_100MHz);
        #2 reset_btn_n = 1'b1;
        wr_count = 0;
        repeat (20) @(negedge clk_100MHz);
        #1;
        chk("midrst_no_wr_after", wr_count, 0);
        lat = 3;
        push_sample(16'h3344);
        wait_idle("drain_after_rst", 200);
        chk("after_rst_wr_pulses", wr_count, 2);

        // Partial sample timeout, then a clean sample
        rx_q.push_back(8'hAA);
        n = 0;
        while (!rd_uart && n < 20) begin @(negedge clk_100MHz); #1; n++; end
        chk("tmo_pop_seen", rd_uart, 1);
        t0 = cyc;
        @(negedge clk_100MHz); #1;
        chk("tmo_busy_partial", busy, 1);
        n = 0;
        while (!timeout_tick && n < 40) begin @(negedge clk_100MHz); #1; n++; end
        chk("tmo_latency", ((cyc - t0) >= 15 && (cyc - t0) <= 18), 1);
        @(negedge clk_100MHz); #1;
        chk("tmo_tick_one_shot", timeout_tick, 0);
        chk("tmo_idle_after", busy, 0);
        push_sample(16'h0201);
        wait_idle("drain_tmo", 200);

        // Randomized traffic with random stalls and filter latency
        ready_mode = 1;
        tx_mode = 0;
        for (int i = 0; i < 30; i++) begin
            lat = $urandom_range(1, 6);
            push_sample(SW'($urandom));
            repeat ($urandom_range(0, 30)) @(negedge clk_100MHz);
        end
        wait_idle("drain_random", 5000);
        chk("final_exp_tx_left", exp_tx.size(), 0);
        chk("final_ticks", ticks_seen, 1);
`ifdef SEQ_STATS_EN
        #1;
        chk("stats_sample_count", sample_count, tx_bytes / SB);
        chk("stats_drop_count", drop_count, ticks_seen);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
